// File: rtl/poly_synth_core_if.sv
// Key-event channel between the keypad/lookup front end and poly_synth_core.
//   ev_valid  key event offered (master -> slave)
//   ev_ready  event accepted when ev_valid & ev_ready (slave -> master)
//   ev_on     1 = key-on, 0 = key-off
//   ev_key    key id 0..14 (15 is accepted and ignored)
//   ev_inc    phase increment for key-on, PHASE_W bits
interface poly_synth_core_if #(
  parameter int unsigned PHASE_W = 16
);
  logic               ev_valid;
  logic               ev_ready;
  logic               ev_on;
  logic [3:0]         ev_key;
  logic [PHASE_W-1:0] ev_inc;

  modport master (output ev_valid, ev_on, ev_key, ev_inc, input ev_ready);
  modport slave  (input ev_valid, ev_on, ev_key, ev_inc, output ev_ready);
endinterface

// File: rtl/poly_synth_core.sv
// Polyphonic synth core: VOICES phase-accumulator voices with key-event
// allocation (retrigger, lowest free voice, round-robin steal), a global
// waveshape mode, an averaging mixer and an 8-bit PWM output stage.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   en            1 = phases run; 0 = phases frozen, mix forced to 128
//   mode_edge     1-cycle pulse advancing the waveshape mode
//   ev            key-event channel (slave side)
//   mode          0 square, 1 saw, 2 triangle, 3 mute
//   voice_active  per-voice busy flags
//   sample_o      mixed unsigned sample (128 = silence), sample_valid pulses on update
//   pwm_o         PWM audio output
module poly_synth_core #(
  parameter int unsigned VOICES     = 4,
  parameter int unsigned PHASE_W    = 16,
  parameter int unsigned SAMPLE_DIV = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode_edge,
  poly_synth_core_if.slave   ev,
  output logic [1:0]         mode,
  output logic [VOICES-1:0]  voice_active,
  output logic [7:0]         sample_o,
  output logic               sample_valid,
  output logic               pwm_o
);

  localparam int unsigned LV    = $clog2(VOICES);
  localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);
  localparam int unsigned SUM_W = 8 + LV;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_MUTE   = 2'd3
  } mode_t;

  logic [CNT_W-1:0]   tick_cnt;
  logic               tick;
  logic               accept;
  logic [VOICES-1:0]  active;
  logic [3:0]         key_q     [VOICES];
  logic [PHASE_W-1:0] inc_q     [VOICES];
  logic [PHASE_W-1:0] phase_q   [VOICES];
  logic [PHASE_W-1:0] phase_adv [VOICES];
  logic [LV-1:0]      steal_ptr;
  mode_t              mode_q;
  logic [7:0]         pwm_cnt;

  logic               hit;
  logic [LV-1:0]      hit_idx;
  logic               free_found;
  logic [LV-1:0]      free_idx;
  logic [LV-1:0]      load_idx;
  logic [7:0]         p;
  logic [7:0]         vv;
  logic [SUM_W-1:0]   sum;
  logic [7:0]         mix;

  assign tick         = (tick_cnt == CNT_W'(SAMPLE_DIV - 1));
  // Events are held off on tick cycles so phase advance and voice loads never collide.
  assign ev.ev_ready  = !rst && !tick;
  assign accept       = ev.ev_valid && ev.ev_ready;
  assign mode         = mode_q;
  assign voice_active = active;

  // Holder lookup and lowest free voice; first match wins.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < VOICES; i++) begin
      if (!hit && active[i] && key_q[i] == ev.ev_key) begin
        hit     = 1'b1;
        hit_idx = LV'(i);
      end
      if (!free_found && !active[i]) begin
        free_found = 1'b1;
        free_idx   = LV'(i);
      end
    end
    load_idx = free_found ? free_idx : steal_ptr;
  end

  // Mixer works on the post-advance phases so the sample registered on the
  // tick edge already reflects the updated voices.
  always_comb begin
    sum = '0;
    p   = '0;
    vv  = '0;
    for (int unsigned i = 0; i < VOICES; i++) begin
      phase_adv[i] = active[i] ? phase_q[i] + inc_q[i] : phase_q[i];
      p = phase_adv[i][PHASE_W-1 -: 8];
      case (mode_q)
        MODE_SQUARE: vv = p[7] ? 8'd255 : 8'd0;
        MODE_SAW:    vv = p;
        MODE_TRI:    vv = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
        default:     vv = 8'd128;
      endcase
      if (!active[i]) vv = 8'd128;
      sum = sum + SUM_W'(vv);
    end
    mix = sum[SUM_W-1:LV];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt     <= '0;
      active       <= '0;
      steal_ptr    <= '0;
      mode_q       <= MODE_SQUARE;
      sample_o     <= 8'd128;
      sample_valid <= 1'b0;
      pwm_cnt      <= '0;
      pwm_o        <= 1'b0;
      for (int unsigned i = 0; i < VOICES; i++) begin
        key_q[i]   <= '0;
        inc_q[i]   <= '0;
        phase_q[i] <= '0;
      end
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);

      if (tick && en) begin
        for (int unsigned i = 0; i < VOICES; i++) phase_q[i] <= phase_adv[i];
      end

      if (accept && ev.ev_key != 4'hF) begin
        if (ev.ev_on) begin
          if (hit) begin
            phase_q[hit_idx] <= '0;
            inc_q[hit_idx]   <= ev.ev_inc;
          end else begin
            active[load_idx]  <= 1'b1;
            key_q[load_idx]   <= ev.ev_key;
            inc_q[load_idx]   <= ev.ev_inc;
            phase_q[load_idx] <= '0;
            if (!free_found) steal_ptr <= steal_ptr + LV'(1);
          end
        end else if (hit) begin
          active[hit_idx]  <= 1'b0;
          phase_q[hit_idx] <= '0;
        end
      end

      if (mode_edge) mode_q <= mode_t'(mode_q + 2'd1);

      sample_valid <= tick;
      if (tick) sample_o <= en ? mix : 8'd128;

      pwm_cnt <= pwm_cnt + 8'd1;
      pwm_o   <= (pwm_cnt < sample_o);
    end
  end

endmodule
